latch_dump_serializer: RTL
==========================

// Module: latch_dump_serializer
// PURPOSE
//  Parametrised serializer that dumps N_CH pipeline latch / debug channels
//  (IF_ID, ID_EX, EX_MEM, MEM_WB, register or memory words, ...) to the UART TX
//  one byte at a time. It sits between the debug channel buses and uart_tx.
//  It generalises the fixed per-latch dump: the channel count, channel width and
//  channel selection mask are set at build time or run time.
// PARAMETERS
//  NB_DATA   8    UART byte width; fixed at 8
//  NB_CH     144  width in bits of each channel slot; narrower latches are zero-extended by the instantiator
//  N_CH      4    number of channels
//  NB_BYTES  ceil(NB_CH/8)  derived localparam: bytes sent per channel
// PORTS
//  i_clk        in   1            system clock
//  i_reset      in   1            asynchronous, active-high reset
//  i_channels   in   N_CH*NB_CH   flat bus; channel k is bits [k*NB_CH +: NB_CH]
//  i_ch_mask    in   N_CH         bit k=1: channel k is included in the dump
//  i_start      in   1            request a dump; sampled only in IDLE
//  i_tx_done    in   1            one-cycle pulse from uart_tx: byte has been sent
//  o_tx_data    out  NB_DATA      byte for uart_tx
//  o_tx_start   out  1            one-cycle pulse that launches o_tx_data
//  o_busy       out  1            high from the cycle after i_start until DONE
//  o_done       out  1            one-cycle pulse when the dump is complete
// BEHAVIOUR
//  Reset: every output is 0, state is IDLE, snapshot and counters are cleared.
//   Reset is asynchronous and may occur mid-frame: the block returns to IDLE
//   immediately. No further o_tx_start is issued, and no o_done is issued.
//  FSM: IDLE -> SEEK -> SEND -> WAIT -> (SEND | SEEK | CSUM | DONE) -> IDLE.
//  IDLE: when i_start=1, capture i_channels and i_ch_mask into snapshot registers,
//   set ch_idx=0 and byte_idx=NB_BYTES-1, then go to SEEK.
//   Input changes during a dump have no effect on it.
//  SEEK: takes one cycle. Selects the lowest channel index >= ch_idx whose mask bit
//   is set, then goes to SEND. If no such channel exists, goes to CSUM or DONE.
//  SEND: drive o_tx_data with byte byte_idx of the selected channel and pulse
//   o_tx_start for exactly 1 cycle, then go to WAIT.
//   Bytes are sent MSB first: byte NB_BYTES-1 down to byte 0.
//   Unused top bits of byte NB_BYTES-1 are sent as 0.
//  WAIT: o_tx_data stays stable. On i_tx_done:
//   - if byte_idx>0: decrement byte_idx and go to SEND;
//   - otherwise: set ch_idx=sel+1, byte_idx=NB_BYTES-1, and go to SEEK.
//   i_tx_done in any other state is ignored.
//  DONE: o_done=1 and o_busy=0 for one cycle, then go to IDLE.
//   A new i_start is accepted on the cycle after DONE.
//  i_start while busy is ignored; it is not queued.
//  Mask all-zero: IDLE -> SEEK -> DONE. No bytes are sent.
//   o_done pulses 2 cycles after i_start is sampled.
//  Latency: first o_tx_start occurs 2 cycles after i_start is sampled.
//   Each subsequent o_tx_start occurs 1 cycle after the i_tx_done that
//   precedes it.
//   A channel boundary adds 1 SEEK cycle.
//  Channel order is ascending index. Total bytes = popcount(mask)*NB_BYTES
//   (+1 when the checksum is enabled).
// CONFIGURATION
//  LATCH_DUMP_CHECKSUM_EN defined:
//   - an 8-bit running XOR of every byte sent is kept; it is cleared in IDLE on i_start;
//   - after the last data byte, state CSUM sends the XOR as one extra byte
//     (SEND/WAIT handshake), then goes to DONE;
//   - with an all-zero mask, the checksum byte 0x00 is still sent.
//  LATCH_DUMP_CHECKSUM_EN undefined: CSUM state and the XOR register do not
//   exist, and the frame carries data bytes only.
// TESTING  (N_CH=4, NB_CH=16 unless noted; uart_tx model returns i_tx_done 10 cycles after o_tx_start)
//  1. ch={0xDEF0,0x9ABC,0x5678,0x1234} (ch3..ch0), mask=4'b0101, start -> bytes 0x12,0x34,0x9A,0xBC, then one o_done pulse
//  2. same channels, mask=4'b0011, CHECKSUM_EN -> 0x12,0x34,0x56,0x78,0x08, then o_done
//  3. mask=4'b0000 -> no o_tx_start; o_done 2 cycles after start (0x00 byte if CHECKSUM_EN)
//  4. NB_CH=12, N_CH=1, ch0=0xABC -> bytes 0x0A,0xBC
//  5. i_start pulsed and i_channels changed during the dump -> byte stream unchanged; no second dump
//  6. assert i_reset between byte 2 and byte 3 -> outputs 0 at once; no o_done; a new start works normally

Source files
------------

// File: rtl/latch_dump_serializer.sv
// latch_dump_serializer
//  Dumps N_CH debug/pipeline-latch channels to a byte-wide UART transmitter.
//  A dump snapshots all channels and the channel mask on i_start. It then walks the
//  selected channels in ascending order and sends each one MSB byte first, using a
//  start/done handshake with uart_tx.
//  Optional build macro: LATCH_DUMP_CHECKSUM_EN appends an XOR checksum byte to the frame.
module latch_dump_serializer #(
   parameter int NB_DATA = 8,
   parameter int NB_CH   = 144,
   parameter int N_CH    = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [N_CH*NB_CH-1:0]   i_channels,
   input  logic [N_CH-1:0]         i_ch_mask,
   input  logic                    i_start,
   input  logic                    i_tx_done,
   output logic [NB_DATA-1:0]      o_tx_data,
   output logic                    o_tx_start,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int NB_BYTES = (NB_CH + 7) / 8;
   localparam int NB_PAD   = NB_BYTES * 8;
   localparam int NB_SEL   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int NB_CIDX  = $clog2(N_CH + 1);
   localparam int NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_BIDX-1:0] BYTE_TOP = NB_BIDX'(NB_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEEK,
      S_SEND,
      S_WAIT,
`ifdef LATCH_DUMP_CHECKSUM_EN
      S_CSUM,
      S_CWAIT,
`endif
      S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [N_CH*NB_CH-1:0]    r_snap;
   logic [N_CH-1:0]          r_mask;
   logic [NB_CIDX-1:0]       r_ch_idx;
   logic [NB_SEL-1:0]        r_sel;
   logic [NB_BIDX-1:0]       r_byte_idx;
   logic [N_CH-1:0]          w_hit;
   logic                     w_found;
   logic [NB_SEL-1:0]        w_sel;
   logic [NB_PAD-1:0]        w_cur;
   logic [NB_DATA-1:0]       w_byte;
`ifdef LATCH_DUMP_CHECKSUM_EN
   logic [NB_DATA-1:0]       r_csum;
`endif

   // A channel is a candidate when it is masked in and not yet passed.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
      assign w_hit[gi] = r_mask[gi] & (NB_CIDX'(gi) >= r_ch_idx);
   end

   // Priority pick of the lowest candidate channel.
   always_comb begin
      w_found = |w_hit;
      w_sel   = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_hit[k]) w_sel = NB_SEL'(k);
      end
   end

   // Current byte: selected channel zero-extended to whole bytes, then byte byte_idx.
   assign w_cur  = NB_PAD'(r_snap[r_sel*NB_CH +: NB_CH]);
   assign w_byte = w_cur[r_byte_idx*8 +: NB_DATA];

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state and output decode.
   always_comb begin
      w_state_next = r_state;
      o_tx_data    = '0;
      o_tx_start   = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = S_SEEK;
         end
         S_SEEK: begin
            o_busy = 1'b1;
            if (w_found) w_state_next = S_SEND;
`ifdef LATCH_DUMP_CHECKSUM_EN
            else         w_state_next = S_CSUM;
`else
            else         w_state_next = S_DONE;
`endif
         end
         S_SEND: begin
            o_busy       = 1'b1;
            o_tx_start   = 1'b1;
            o_tx_data    = w_byte;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            o_busy    = 1'b1;
            o_tx_data = w_byte;
            if (i_tx_done) w_state_next = (r_byte_idx != '0) ? S_SEND : S_SEEK;
         end
`ifdef LATCH_DUMP_CHECKSUM_EN
         S_CSUM: begin
            o_busy       = 1'b1;
            o_tx_start   = 1'b1;
            o_tx_data    = r_csum;
            w_state_next = S_CWAIT;
         end
         S_CWAIT: begin
            o_busy    = 1'b1;
            o_tx_data = r_csum;
            if (i_tx_done) w_state_next = S_DONE;
         end
`endif
         S_DONE: begin
            o_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Snapshot, channel/byte walk and running checksum.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_snap     <= '0;
         r_mask     <= '0;
         r_ch_idx   <= '0;
         r_sel      <= '0;
         r_byte_idx <= '0;
`ifdef LATCH_DUMP_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_snap     <= i_channels;
                  r_mask     <= i_ch_mask;
                  r_ch_idx   <= '0;
                  r_byte_idx <= BYTE_TOP;
`ifdef LATCH_DUMP_CHECKSUM_EN
                  r_csum     <= '0;
`endif
               end
            end
            S_SEEK: begin
               if (w_found) r_sel <= w_sel;
            end
`ifdef LATCH_DUMP_CHECKSUM_EN
            S_SEND: r_csum <= r_csum ^ w_byte;
`endif
            S_WAIT: begin
               if (i_tx_done) begin
                  if (r_byte_idx != '0) begin
                     r_byte_idx <= r_byte_idx - 1'b1;
                  end else begin
                     r_ch_idx   <= NB_CIDX'(r_sel) + NB_CIDX'(1);
                     r_byte_idx <= BYTE_TOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
